// File: rtl/apb_master_arb_pkg.sv
// ============================================================================
// apb_master_arb_pkg : shared FSM encodings and default widths | rev 1.0
// ============================================================================
`default_nettype none

package apb_master_arb_pkg;

  localparam int DEF_DATA_SIZE = 32;
  localparam int DEF_ADDR_SIZE = 6;
  localparam int DEF_TIMEOUT   = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } apb_state_t;

endpackage

`default_nettype wire

// File: rtl/apb_master_arb_rr_arb2.sv
// ============================================================================
// rr_arb2 : two-way round-robin arbiter, ptr = last granted index | rev 1.0
// ============================================================================
`default_nettype none

module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/apb_master_arb.sv
// ============================================================================
// apb_master_arb : two-requester APB master with round-robin arbitration
// and ACCESS timeout; every output is registered | rev 1.0
// ============================================================================
`default_nettype none

module apb_master_arb
  import apb_master_arb_pkg::*;
#(
  parameter int DATA_SIZE = DEF_DATA_SIZE,
  parameter int ADDR_SIZE = DEF_ADDR_SIZE,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic                       PCLK,
  input  logic                       PRESETn,
  input  logic [1:0]                 req,
  input  logic [1:0]                 req_write,
  input  logic [2*ADDR_SIZE-1:0]     req_addr,
  input  logic [2*DATA_SIZE-1:0]     req_wdata,
  input  logic [2*(DATA_SIZE/8)-1:0] req_strobe,
  output logic [1:0]                 done,
  output logic [DATA_SIZE-1:0]       rdata,
  output logic                       err,
  output logic [ADDR_SIZE-1:0]       PADDR,
  output logic                       PSEL,
  output logic                       PENABLE,
  output logic                       PWRITE,
  output logic [DATA_SIZE-1:0]       PWDATA,
  output logic [DATA_SIZE/8-1:0]     PSTROBE,
  input  logic [DATA_SIZE-1:0]       PRDATA,
  input  logic                       PREADY,
  input  logic                       PSLVERR
);

  localparam int STRB_SIZE = DATA_SIZE / 8;
  localparam int CNT_W     = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  apb_state_t             state, state_n;
  logic [CNT_W-1:0]       cnt, cnt_n;
  logic                   ptr, ptr_n;
  logic [1:0]             grant, grant_n;
  logic [1:0]             arb_req, arb_grant;
  logic [1:0]             done_n;
  logic                   err_n;
  logic [DATA_SIZE-1:0]   rdata_n;
  logic [ADDR_SIZE-1:0]   paddr_n;
  logic                   psel_n, penable_n, pwrite_n;
  logic [DATA_SIZE-1:0]   pwdata_n;
  logic [STRB_SIZE-1:0]   pstrobe_n;

  // Candidate requester for the selected load point: the requester just
  // served (or still being acknowledged) is masked out for that cycle.
  always_comb begin
    arb_req = 2'b00;
    case (state)
      IDLE:    arb_req = req & ~done;
      ACCESS:  arb_req = req & ~grant;
      default: arb_req = 2'b00;
    endcase
  end

  rr_arb2 u_rr_arb2 (
    .req   (arb_req),
    .ptr   (ptr),
    .grant (arb_grant)
  );

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    ptr_n     = ptr;
    grant_n   = grant;
    done_n    = 2'b00;
    err_n     = 1'b0;
    rdata_n   = rdata;
    paddr_n   = PADDR;
    psel_n    = PSEL;
    penable_n = PENABLE;
    pwrite_n  = PWRITE;
    pwdata_n  = PWDATA;
    pstrobe_n = PSTROBE;

    case (state)
      IDLE: begin
        psel_n    = 1'b0;
        penable_n = 1'b0;
        if (|arb_req) begin
          state_n = SETUP;
          psel_n  = 1'b1;
        end
      end
      SETUP: begin
        state_n   = ACCESS;
        penable_n = 1'b1;
        cnt_n     = '0;
      end
      ACCESS: begin
        if (PREADY || (cnt == CNT_LAST)) begin
          done_n    = grant;
          err_n     = PREADY ? PSLVERR : 1'b1;
          penable_n = 1'b0;
          if (PREADY && !PWRITE) begin
            rdata_n = PRDATA;
          end
          // A timeout always returns to IDLE; a normal completion chains
          // straight into the next SETUP when the other requester waits.
          if (PREADY && (|arb_req)) begin
            state_n = SETUP;
            psel_n  = 1'b1;
          end else begin
            state_n = IDLE;
            psel_n  = 1'b0;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n   = IDLE;
        psel_n    = 1'b0;
        penable_n = 1'b0;
      end
    endcase

    if ((state_n == SETUP) && (state != SETUP)) begin
      grant_n   = arb_grant;
      ptr_n     = arb_grant[1];
      paddr_n   = arb_grant[1] ? req_addr[2*ADDR_SIZE-1:ADDR_SIZE] : req_addr[ADDR_SIZE-1:0];
      pwrite_n  = arb_grant[1] ? req_write[1] : req_write[0];
      pwdata_n  = '0;
      pstrobe_n = '0;
      if (pwrite_n) begin
        pwdata_n  = arb_grant[1] ? req_wdata[2*DATA_SIZE-1:DATA_SIZE] : req_wdata[DATA_SIZE-1:0];
        pstrobe_n = arb_grant[1] ? req_strobe[2*STRB_SIZE-1:STRB_SIZE] : req_strobe[STRB_SIZE-1:0];
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state   <= IDLE;
      cnt     <= '0;
      ptr     <= 1'b1;
      grant   <= 2'b00;
      done    <= 2'b00;
      err     <= 1'b0;
      rdata   <= '0;
      PADDR   <= '0;
      PSEL    <= 1'b0;
      PENABLE <= 1'b0;
      PWRITE  <= 1'b0;
      PWDATA  <= '0;
      PSTROBE <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      ptr     <= ptr_n;
      grant   <= grant_n;
      done    <= done_n;
      err     <= err_n;
      rdata   <= rdata_n;
      PADDR   <= paddr_n;
      PSEL    <= psel_n;
      PENABLE <= penable_n;
      PWRITE  <= pwrite_n;
      PWDATA  <= pwdata_n;
      PSTROBE <= pstrobe_n;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_apb_master_arb.sv
// ============================================================================
// tb_apb_master_arb : directed self-checking bench for apb_master_arb | rev 1.0
// ============================================================================
`default_nettype none

module tb_apb_master_arb;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic [1:0]  req, req_write;
  logic [11:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_strobe;
  logic [1:0]  done;
  logic [31:0] rdata;
  logic        err;
  logic [5:0]  PADDR;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PWDATA;
  logic [3:0]  PSTROBE;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;

  int checks   = 0;
  int failures = 0;

  always #5 PCLK = ~PCLK;

  apb_master_arb dut (
    .PCLK       (PCLK),
    .PRESETn    (PRESETn),
    .req        (req),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_strobe (req_strobe),
    .done       (done),
    .rdata      (rdata),
    .err        (err),
    .PADDR      (PADDR),
    .PSEL       (PSEL),
    .PENABLE    (PENABLE),
    .PWRITE     (PWRITE),
    .PWDATA     (PWDATA),
    .PSTROBE    (PSTROBE),
    .PRDATA     (PRDATA),
    .PREADY     (PREADY),
    .PSLVERR    (PSLVERR)
  );

  task automatic test_reset();
    PRESETn = 1'b0; req = 2'b00; req_write = 2'b00; req_addr = '0;
    req_wdata = '0; req_strobe = '0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    repeat (3) @(negedge PCLK);
    checks++; if ({PSEL, PENABLE} !== 2'b00) begin failures++; $display("FAIL reset_psel_penable got %b expected 00", {PSEL, PENABLE}); end
    checks++; if (done !== 2'b00) begin failures++; $display("FAIL reset_done got %b expected 00", done); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got %b expected 0", err); end
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got %h expected 0", rdata); end
    checks++; if ({PADDR, PWRITE, PWDATA, PSTROBE} !== 43'h0) begin failures++; $display("FAIL reset_apb_bus got %h expected 0", {PADDR, PWRITE, PWDATA, PSTROBE}); end
    PRESETn = 1'b1;
  endtask

  task automatic test_single_write();
    @(negedge PCLK);
    req = 2'b01; req_write = 2'b01; req_addr = {6'h00, 6'h05};
    req_wdata = {32'h0, 32'h55555555}; req_strobe = 8'h0F; PREADY = 1'b1;
    @(negedge PCLK);
    checks++; if ({PSEL, PENABLE} !== 2'b10) begin failures++; $display("FAIL wr_setup_sel_en got %b expected 10", {PSEL, PENABLE}); end
    checks++; if ({PADDR, PWRITE} !== {6'h05, 1'b1}) begin failures++; $display("FAIL wr_setup_addr_dir got %h expected %h", {PADDR, PWRITE}, {6'h05, 1'b1}); end
    checks++; if ({PWDATA, PSTROBE} !== {32'h55555555, 4'hF}) begin failures++; $display("FAIL wr_setup_data_strb got %h expected %h", {PWDATA, PSTROBE}, {32'h55555555, 4'hF}); end
    checks++; if (done !== 2'b00) begin failures++; $display("FAIL wr_setup_done got %b expected 00", done); end
    @(negedge PCLK);
    checks++; if ({PSEL, PENABLE} !== 2'b11) begin failures++; $display("FAIL wr_access_sel_en got %b expected 11", {PSEL, PENABLE}); end
    checks++; if ({PADDR, PWRITE, PWDATA, PSTROBE} !== {6'h05, 1'b1, 32'h55555555, 4'hF}) begin failures++; $display("FAIL wr_access_stable got %h", {PADDR, PWRITE, PWDATA, PSTROBE}); end
    @(negedge PCLK);
    checks++; if ({done, err} !== 3'b010) begin failures++; $display("FAIL wr_done_err got %b expected 010", {done, err}); end
    checks++; if ({PSEL, PENABLE} !== 2'b00) begin failures++; $display("FAIL wr_back_idle got %b expected 00", {PSEL, PENABLE}); end
    req = 2'b00;
    @(negedge PCLK);
    checks++; if (done !== 2'b00) begin failures++; $display("FAIL wr_done_pulse got %b expected 00", done); end
  endtask

  task automatic test_read_wait();
    @(negedge PCLK);
    req = 2'b10; req_write = 2'b00; req_addr = {6'h0A, 6'h00};
    req_wdata = {32'hAAAA5555, 32'h0}; req_strobe = 8'hF0;
    PREADY = 1'b0; PRDATA = 32'hDEADBEEF;
    @(negedge PCLK);
    checks++; if ({PSEL, PENABLE, PADDR, PWRITE} !== {2'b10, 6'h0A, 1'b0}) begin failures++; $display("FAIL rd_setup got %h expected %h", {PSEL, PENABLE, PADDR, PWRITE}, {2'b10, 6'h0A, 1'b0}); end
    checks++; if ({PWDATA, PSTROBE} !== 36'h0) begin failures++; $display("FAIL rd_zero_wdata_strobe got %h expected 0", {PWDATA, PSTROBE}); end
    for (int i = 0; i < 3; i++) begin
      @(negedge PCLK);
      checks++; if ({PSEL, PENABLE, done} !== 4'b1100) begin failures++; $display("FAIL rd_wait_%0d got %b expected 1100", i, {PSEL, PENABLE, done}); end
      if (i == 2) PREADY = 1'b1;
    end
    @(negedge PCLK);
    checks++; if ({done, err} !== 3'b100) begin failures++; $display("FAIL rd_done_err got %b expected 100", {done, err}); end
    checks++; if (rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_rdata got %h expected deadbeef", rdata); end
    checks++; if (PENABLE !== 1'b0) begin failures++; $display("FAIL rd_penable_drop got %b expected 0", PENABLE); end
    req = 2'b00;
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_done [4];
    logic [5:0] exp_addr [4];
    exp_done = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_addr = '{6'h01, 6'h02, 6'h01, 6'h02};
    @(negedge PCLK);
    req = 2'b11; req_write = 2'b11; req_addr = {6'h02, 6'h01};
    req_wdata = {32'h22222222, 32'h11111111}; req_strobe = 8'hFF; PREADY = 1'b1;
    @(negedge PCLK);
    for (int k = 0; k < 4; k++) begin
      checks++; if ({PSEL, PENABLE, PADDR} !== {2'b10, exp_addr[k]}) begin failures++; $display("FAIL rr_setup_%0d got %h expected %h", k, {PSEL, PENABLE, PADDR}, {2'b10, exp_addr[k]}); end
      @(negedge PCLK);
      checks++; if ({PSEL, PENABLE} !== 2'b11) begin failures++; $display("FAIL rr_access_%0d got %b expected 11", k, {PSEL, PENABLE}); end
      @(negedge PCLK);
      checks++; if (done !== exp_done[k]) begin failures++; $display("FAIL rr_done_%0d got %b expected %b", k, done, exp_done[k]); end
      if (k >= 2) req = req & ~exp_done[k];
    end
    checks++; if (PSEL !== 1'b0) begin failures++; $display("FAIL rr_final_idle got %b expected 0", PSEL); end
  endtask

  task automatic test_timeout();
    int acc;
    bit seen;
    @(negedge PCLK);
    req = 2'b01; req_write = 2'b00; req_addr = {6'h00, 6'h07};
    PREADY = 1'b0; PRDATA = 32'h12345678;
    acc = 0; seen = 1'b0;
    @(negedge PCLK);
    for (int i = 0; i < 40; i++) begin
      @(negedge PCLK);
      if (done !== 2'b00) begin seen = 1'b1; break; end
      if (PENABLE === 1'b1) acc++;
    end
    checks++; if (!seen) begin failures++; $display("FAIL to_no_done got none expected done within 40 cycles"); end
    checks++; if (acc !== 16) begin failures++; $display("FAIL to_access_cycles got %0d expected 16", acc); end
    checks++; if ({done, err} !== 3'b011) begin failures++; $display("FAIL to_done_err got %b expected 011", {done, err}); end
    checks++; if (rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL to_rdata_hold got %h expected deadbeef", rdata); end
    checks++; if ({PSEL, PENABLE} !== 2'b00) begin failures++; $display("FAIL to_drop got %b expected 00", {PSEL, PENABLE}); end
    req = 2'b00;
    @(negedge PCLK);
    checks++; if ({PSEL, done, err} !== 4'b0000) begin failures++; $display("FAIL to_idle got %b expected 0000", {PSEL, done, err}); end
  endtask

  task automatic test_slverr();
    @(negedge PCLK);
    req = 2'b01; req_write = 2'b01; req_addr = {6'h00, 6'h3F};
    req_wdata = {32'h0, 32'hCAFEF00D}; req_strobe = 8'h03; PREADY = 1'b1; PSLVERR = 1'b1;
    @(negedge PCLK);
    checks++; if ({PADDR, PSTROBE} !== {6'h3F, 4'h3}) begin failures++; $display("FAIL se_setup got %h expected %h", {PADDR, PSTROBE}, {6'h3F, 4'h3}); end
    @(negedge PCLK);
    @(negedge PCLK);
    checks++; if ({done, err} !== 3'b011) begin failures++; $display("FAIL se_done_err got %b expected 011", {done, err}); end
    req = 2'b00; PSLVERR = 1'b0;
    @(negedge PCLK);
    checks++; if ({done, err} !== 3'b000) begin failures++; $display("FAIL se_err_clear got %b expected 000", {done, err}); end
  endtask

  task automatic test_reset_mid();
    @(negedge PCLK);
    req = 2'b01; req_write = 2'b00; req_addr = {6'h00, 6'h11}; PREADY = 1'b0;
    @(negedge PCLK);
    @(negedge PCLK);
    checks++; if ({PSEL, PENABLE} !== 2'b11) begin failures++; $display("FAIL rm_in_access got %b expected 11", {PSEL, PENABLE}); end
    #2 PRESETn = 1'b0;
    #1;
    checks++; if ({PSEL, PENABLE, done} !== 4'b0000) begin failures++; $display("FAIL rm_async_drop got %b expected 0000", {PSEL, PENABLE, done}); end
    req = 2'b00;
    @(negedge PCLK);
    checks++; if ({done, err} !== 3'b000) begin failures++; $display("FAIL rm_no_done got %b expected 000", {done, err}); end
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL rm_rdata_clear got %h expected 0", rdata); end
    PRESETn = 1'b1;
    @(negedge PCLK);
    req = 2'b11; req_write = 2'b11; req_addr = {6'h22, 6'h21};
    req_wdata = {32'hBBBBBBBB, 32'hAAAAAAAA}; req_strobe = 8'hFF; PREADY = 1'b1;
    @(negedge PCLK);
    checks++; if ({PSEL, PADDR} !== {1'b1, 6'h21}) begin failures++; $display("FAIL rm_first_grant got %h expected %h", {PSEL, PADDR}, {1'b1, 6'h21}); end
    @(negedge PCLK);
    @(negedge PCLK);
    checks++; if (done !== 2'b01) begin failures++; $display("FAIL rm_done0 got %b expected 01", done); end
    req = 2'b00;
    @(negedge PCLK);
    @(negedge PCLK);
    checks++; if (done !== 2'b10) begin failures++; $display("FAIL rm_done1 got %b expected 10", done); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read_wait();
    test_back_to_back();
    test_timeout();
    test_slverr();
    test_reset_mid();
    @(negedge PCLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/apb_master_arb.md
APB_MASTER_ARB -- requirements
Module: apb_master_arb

Interface
REQ-001 Parameter DATA_SIZE, default 32: APB data width, multiple of 8.
REQ-002 Parameter ADDR_SIZE, default 6: APB address width.
REQ-003 Parameter TIMEOUT, default 16: maximum ACCESS cycles waited for PREADY.
REQ-004 The block SHALL use one clock and an asynchronous active-low reset; port rows follow.
REQ-005 PCLK  in  1  clock; all state updates on rising edge.
REQ-006 PRESETn  in  1  asynchronous active-low reset.
REQ-007 req  in  2  per-requester transfer request; held high until matching done.
REQ-008 req_write  in  2  per-requester direction: 1 = write.
REQ-009 req_addr  in  2*ADDR_SIZE  requester i address at [i*ADDR_SIZE +: ADDR_SIZE].
REQ-010 req_wdata  in  2*DATA_SIZE  requester i write data, same slicing.
REQ-011 req_strobe  in  2*(DATA_SIZE/8)  requester i byte strobes, same slicing.
REQ-012 done  out  2  one-cycle pulse to the requester whose transfer completed.
REQ-013 rdata  out  DATA_SIZE  read data, valid in the done cycle.
REQ-014 err  out  1  error flag, valid in the done cycle (PSLVERR or timeout).
REQ-015 PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTROBE  out  APB master signals, widths ADDR_SIZE, 1, 1, 1, DATA_SIZE, DATA_SIZE/8.
REQ-016 PRDATA  in  DATA_SIZE; PREADY  in  1; PSLVERR  in  1: APB slave responses.

Function
REQ-017 The FSM SHALL have states IDLE, SETUP, ACCESS; all outputs SHALL be registered.
REQ-018 IDLE: PSEL=0, PENABLE=0; on any req bit high, grant one requester, latch its addr/write/wdata/strobe, go to SETUP.
REQ-019 Arbitration SHALL be round-robin: if both request, grant the one not granted last; pointer resets so requester 0 wins first.
REQ-020 SETUP: PSEL=1, PENABLE=0, one cycle, then unconditionally ACCESS with PENABLE=1; APB outputs stable SETUP through ACCESS.
REQ-021 ACCESS with PREADY=1: pulse done[grant], capture PRDATA into rdata if read (rdata holds otherwise), err=PSLVERR.
REQ-022 After completion: if any req other than the just-completed requester's is high, go directly to SETUP with the new grant (PENABLE=0, PSEL stays 1); else IDLE.
REQ-023 The completed requester's req SHALL be ignored in the completion cycle (it may still be high for one cycle).
REQ-024 ACCESS with PREADY low for TIMEOUT consecutive cycles: abort, done[grant]=1, err=1, rdata unchanged, PSEL/PENABLE drop next cycle.
REQ-025 PSTROBE SHALL be driven 0 for reads; PWDATA SHALL be 0 for reads.
REQ-026 Latency: req sampled high at edge N -> PSEL=1 after N, PENABLE=1 after N+1, done after N+2 with zero-wait slave.
REQ-027 A requester dropping req mid-transfer SHALL NOT abort it; the latched transfer completes.
REQ-028 err and done SHALL be 0 except in a completion cycle.

Reset
REQ-029 While PRESETn=0: state=IDLE, all APB outputs, done, err, rdata, timeout counter = 0; round-robin pointer = 1.
REQ-030 Reset asserted mid-transfer SHALL drop PSEL/PENABLE immediately with no done pulse.

Structure
REQ-031 State encodings (IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10) and default widths SHALL live in a shared package/include.
REQ-032 Round-robin grant logic SHALL be one sub-module, rr_arb2 (req[1:0], pointer -> one-hot grant).

Verification
REQ-033 Single write: req=2'b01, addr 6'h05, wdata 32'h55555555, strobe 4'hF, PREADY=1 -> PSEL at +1, PENABLE at +2, done=2'b01 at +3, err=0.
REQ-034 Read with 2 wait states: req[1], addr 6'h0A, PRDATA 32'hDEADBEEF -> PENABLE held 3 cycles, done=2'b10, rdata=32'hDEADBEEF.
REQ-035 Both requesting continuously, 4 transfers -> grant order 0,1,0,1, back-to-back SETUP with no IDLE cycle.
REQ-036 PREADY tied 0, TIMEOUT=16 -> done after 16 ACCESS cycles, err=1, then IDLE.
REQ-037 PSLVERR=1 with PREADY=1 on write to addr 6'h3F -> done, err=1 one cycle, err=0 next.
REQ-038 PRESETn pulsed low during ACCESS -> PSEL=PENABLE=0 asynchronously, no done; after release, requester 0 wins a simultaneous request.
